// File: rtl/fpu_cmd_queue.sv
// fpu_cmd_queue: bus-mapped command FIFO feeding a single-issue FPU core,
// plus a result FIFO that the host drains with end_ack.
module fpu_cmd_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] databus_in,
  output logic [DATA_W-1:0] databus_out,
  input  logic [3:0]        addr,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic              end_ack,
  output logic              cmd_end,
  output logic              busy,
  output logic [31:0]       core_a,
  output logic [31:0]       core_b,
  output logic [7:0]        core_op,
  output logic              core_start,
  input  logic              core_done,
  input  logic [31:0]       core_result
);

  localparam int L  = 32 / DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0]    FULL_CNT = 5'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
  state_t state, state_next;

  logic          wr_prev, ack_prev;
  logic          wr_evt, ack_evt;
  logic [31:0]   stage_a, stage_b;
  logic [7:0]    stage_op;
  logic          overflow;

  logic [71:0]   cmd_mem [DEPTH];
  logic [AW-1:0] cmd_wptr, cmd_rptr;
  logic [4:0]    cmd_count;
  logic          cmd_empty, cmd_full, cmd_push, cmd_pop;

  logic [31:0]   res_mem [DEPTH];
  logic [AW-1:0] res_wptr, res_rptr;
  logic [4:0]    res_count;
  logic          res_empty, res_full, res_push, res_pop;
  logic [31:0]   res_hold;
  logic [31:0]   res_head;
  logic [7:0]    status;

  // One write event per falling wr strobe; end_ack acts on its rising edge.
  assign wr_evt  = !cs && !wr && wr_prev;
  assign ack_evt = end_ack && !ack_prev;

  assign cmd_empty = (cmd_count == 5'd0);
  assign cmd_full  = (cmd_count == FULL_CNT);
  assign res_empty = (res_count == 5'd0);
  assign res_full  = (res_count == FULL_CNT);

  assign cmd_push = wr_evt && (addr == 4'h9) && !cmd_full;
  assign cmd_pop  = (state == IDLE) && !cmd_empty && !res_full;
  assign res_push = (state == WB);
  assign res_pop  = ack_evt && !res_empty;

  always_ff @(posedge clk) begin
    if (arst) begin
      wr_prev  <= 1'b1;
      ack_prev <= 1'b1;
    end else begin
      wr_prev  <= wr;
      ack_prev <= end_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      stage_a  <= '0;
      stage_b  <= '0;
      stage_op <= '0;
      overflow <= 1'b0;
    end else if (wr_evt) begin
      for (int n = 0; n < L; n++) begin
        if (addr == 4'(n))     stage_a[n*DATA_W +: DATA_W] <= databus_in;
        if (addr == 4'(4 + n)) stage_b[n*DATA_W +: DATA_W] <= databus_in;
      end
      if (addr == 4'h8) stage_op <= databus_in[7:0];
      if (addr == 4'h9 && cmd_full) overflow <= 1'b1;
      else if (addr == 4'hD)        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wptr] <= {stage_a, stage_b, stage_op};
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cmd_wptr  <= '0;
      cmd_rptr  <= '0;
      cmd_count <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + PTR_ONE;
      if (cmd_pop)  cmd_rptr <= cmd_rptr + PTR_ONE;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 5'd1;
        2'b01:   cmd_count <= cmd_count - 5'd1;
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // Operands stay frozen until the next command is issued.
  always_ff @(posedge clk) begin
    if (arst) begin
      core_a  <= '0;
      core_b  <= '0;
      core_op <= '0;
    end else if (cmd_pop) begin
      {core_a, core_b, core_op} <= cmd_mem[cmd_rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (arst)                            res_hold <= '0;
    else if (state == WAIT && core_done) res_hold <= core_result;
  end

  always_ff @(posedge clk) begin
    if (res_push) res_mem[res_wptr] <= res_hold;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      res_wptr  <= '0;
      res_rptr  <= '0;
      res_count <= '0;
    end else begin
      if (res_push) res_wptr <= res_wptr + PTR_ONE;
      if (res_pop)  res_rptr <= res_rptr + PTR_ONE;
      case ({res_push, res_pop})
        2'b10:   res_count <= res_count + 5'd1;
        2'b01:   res_count <= res_count - 5'd1;
        default: res_count <= res_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) cmd_end <= 1'b0;
    else      cmd_end <= !res_empty;
  end

  always_ff @(posedge clk) begin
    if (arst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    core_start = 1'b0;
    case (state)
      IDLE:    if (cmd_pop) state_next = ISSUE;
      ISSUE: begin
        core_start = !arst;
        state_next = WAIT;
      end
      WAIT:    if (core_done) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = !arst && (!cmd_empty || state != IDLE);

  assign res_head = res_empty ? 32'd0 : res_mem[res_rptr];
  assign status   = {cmd_count[3:0], overflow, !res_empty, cmd_empty, cmd_full};

  always_comb begin
    databus_out = '0;
    if (!arst && !cs && !rd) begin
      for (int n = 0; n < L; n++) begin
        if (addr == 4'(9 + n)) databus_out = res_head[n*DATA_W +: DATA_W];
      end
      if (addr == 4'hD) databus_out[7:0] = status;
    end
  end

endmodule

// File: tb/tb_fpu_cmd_queue.sv
// Bench for fpu_cmd_queue: three instances (8-bit/depth 4, 8-bit/depth 2,
// 32-bit/depth 4) share the bus lines and are selected by their own cs.
module tb_fpu_cmd_queue;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst, wr, rd;
  logic [3:0]  addr;
  logic [31:0] din;
  logic        cs_v [N];
  logic        end_ack_v [N];
  logic        core_done_v [N];
  logic [31:0] core_result_v [N];
  logic [31:0] dout_v [N];
  logic [31:0] core_a_v [N];
  logic [31:0] core_b_v [N];
  logic [7:0]  core_op_v [N];
  logic        start_v [N];
  logic        cmd_end_v [N];
  logic        busy_v [N];
  logic [7:0]  dout0, dout1;
  logic [31:0] dout2;

  assign dout_v[0] = {24'd0, dout0};
  assign dout_v[1] = {24'd0, dout1};
  assign dout_v[2] = dout2;

  fpu_cmd_queue #(.DATA_W(8), .DEPTH(4)) u_dw8 (
    .clk(clk), .arst(arst), .databus_in(din[7:0]), .databus_out(dout0), .addr(addr),
    .cs(cs_v[0]), .rd(rd), .wr(wr), .end_ack(end_ack_v[0]), .cmd_end(cmd_end_v[0]),
    .busy(busy_v[0]), .core_a(core_a_v[0]), .core_b(core_b_v[0]), .core_op(core_op_v[0]),
    .core_start(start_v[0]), .core_done(core_done_v[0]), .core_result(core_result_v[0]));

  fpu_cmd_queue #(.DATA_W(8), .DEPTH(2)) u_dw8_d2 (
    .clk(clk), .arst(arst), .databus_in(din[7:0]), .databus_out(dout1), .addr(addr),
    .cs(cs_v[1]), .rd(rd), .wr(wr), .end_ack(end_ack_v[1]), .cmd_end(cmd_end_v[1]),
    .busy(busy_v[1]), .core_a(core_a_v[1]), .core_b(core_b_v[1]), .core_op(core_op_v[1]),
    .core_start(start_v[1]), .core_done(core_done_v[1]), .core_result(core_result_v[1]));

  fpu_cmd_queue #(.DATA_W(32), .DEPTH(4)) u_dw32 (
    .clk(clk), .arst(arst), .databus_in(din), .databus_out(dout2), .addr(addr),
    .cs(cs_v[2]), .rd(rd), .wr(wr), .end_ack(end_ack_v[2]), .cmd_end(cmd_end_v[2]),
    .busy(busy_v[2]), .core_a(core_a_v[2]), .core_b(core_b_v[2]), .core_op(core_op_v[2]),
    .core_start(start_v[2]), .core_done(core_done_v[2]), .core_result(core_result_v[2]));

  // Issue pulses per instance, used to count how many commands really started.
  int starts [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (start_v[i]) starts[i] <= starts[i] + 1;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    logic [31:0] res;
  } cmd_t;

  typedef struct {
    int          inst;
    bit          write;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] want;
  } vec_t;

  cmd_t        cmd_q [$];
  logic [31:0] res_q [$];
  cmd_t        cur;
  vec_t        vecs [$];
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mkVec(input int i, input bit w, input logic [3:0] a,
                                 input logic [31:0] d, input logic [31:0] x);
    vec_t v;
    v.inst = i; v.write = w; v.addr = a; v.data = d; v.want = x;
    return v;
  endfunction

  function automatic int laneW(input int idx);
    return (idx == 2) ? 32 : 8;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic busWrite(input int idx, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cs_v[idx] = 1'b0; wr = 1'b0; addr = a; din = d;
    @(negedge clk);
    cs_v[idx] = 1'b1; wr = 1'b1;
  endtask

  task automatic busRead(input int idx, input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    cs_v[idx] = 1'b0; rd = 1'b0; addr = a;
    #1 d = dout_v[idx];
    cs_v[idx] = 1'b1; rd = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int k);
    logic [31:0] got;
    if (v.write) busWrite(v.inst, v.addr, v.data);
    else begin
      busRead(v.inst, v.addr, got);
      checkOutput($sformatf("vec%0d_i%0d_a%h", k, v.inst, v.addr), got, v.want);
    end
  endtask

  task automatic pushCmd(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] op, input logic [31:0] res, input bit load_ab);
    int w;
    logic [31:0] m;
    cmd_t c;
    w = laneW(idx);
    m = (w == 32) ? 32'hffff_ffff : 32'h0000_00ff;
    if (load_ab) begin
      for (int n = 0; n < 32 / w; n++) begin
        busWrite(idx, 4'(n), (a >> (n * w)) & m);
        busWrite(idx, 4'(4 + n), (b >> (n * w)) & m);
      end
    end
    busWrite(idx, 4'h8, {24'd0, op});
    busWrite(idx, 4'h9, 32'd0);
    c.a = a; c.b = b; c.op = op; c.res = res;
    cmd_q.push_back(c);
  endtask

  task automatic waitStart(input int idx, output int waited);
    bit seen;
    seen = 1'b0;
    waited = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      waited = c + 1;
      if (start_v[idx] === 1'b1) seen = 1'b1;
    end
    checkOutput($sformatf("start_seen_i%0d", idx), 32'(seen), 32'd1);
    if (seen) begin
      if (cmd_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL sb_cmd got=empty want=entry");
      end else begin
        cur = cmd_q.pop_front();
        checkOutput("core_a", core_a_v[idx], cur.a);
        checkOutput("core_b", core_b_v[idx], cur.b);
        checkOutput("core_op", 32'(core_op_v[idx]), 32'(cur.op));
      end
      checkOutput("busy_issue", 32'(busy_v[idx]), 32'd1);
      @(negedge clk);
      checkOutput("start_width", 32'(start_v[idx]), 32'd0);
    end
  endtask

  task automatic respond(input int idx, input int latency);
    repeat (latency) @(negedge clk);
    core_done_v[idx] = 1'b1; core_result_v[idx] = cur.res;
    @(negedge clk);
    core_done_v[idx] = 1'b0; core_result_v[idx] = ~cur.res;
    res_q.push_back(cur.res);
  endtask

  task automatic readResult(input int idx, input string name);
    logic [31:0] got, part;
    int w;
    w = laneW(idx);
    got = '0;
    for (int n = 0; n < 32 / w; n++) begin
      busRead(idx, 4'(9 + n), part);
      got = got | (part << (n * w));
    end
    if (res_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s got=%h want=no_result", name, got);
    end else checkOutput(name, got, res_q.pop_front());
  endtask

  task automatic ackPulse(input int idx);
    @(negedge clk);
    end_ack_v[idx] = 1'b1;
    @(negedge clk);
    end_ack_v[idx] = 1'b0;
  endtask

  task automatic waitCmdEnd(input int idx);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (cmd_end_v[idx] === 1'b1) seen = 1'b1;
    end
    checkOutput($sformatf("cmd_end_seen_i%0d", idx), 32'(seen), 32'd1);
  endtask

  // Hold reset two cycles with a read strobe active; everything must read zero.
  task automatic doReset();
    arst = 1'b1;
    rd = 1'b0; addr = 4'hD;
    for (int i = 0; i < N; i++) cs_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst_dout%0d", i), dout_v[i], 32'd0);
      checkOutput($sformatf("rst_cmd_end%0d", i), 32'(cmd_end_v[i]), 32'd0);
      checkOutput($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
      checkOutput($sformatf("rst_start%0d", i), 32'(start_v[i]), 32'd0);
    end
    arst = 1'b0; rd = 1'b1;
    for (int i = 0; i < N; i++) cs_v[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst_core_a%0d", i), core_a_v[i], 32'd0);
      checkOutput($sformatf("post_rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
    end
    cmd_q.delete();
    res_q.delete();
  endtask

  initial begin
    logic [31:0] rdata;
    int waited, s0;

    arst = 1'b1; wr = 1'b1; rd = 1'b1; addr = 4'h0; din = 32'd0;
    for (int i = 0; i < N; i++) begin
      cs_v[i] = 1'b1; end_ack_v[i] = 1'b0; core_done_v[i] = 1'b0; core_result_v[i] = 32'd0;
    end

    // Post-reset readback, then fill instance 0 past capacity with core_done low.
    vecs.push_back(mkVec(0, 0, 4'hD, 0, 32'h02));
    vecs.push_back(mkVec(1, 0, 4'hD, 0, 32'h02));
    vecs.push_back(mkVec(2, 0, 4'hD, 0, 32'h02));
    vecs.push_back(mkVec(0, 0, 4'h9, 0, 32'h00));
    vecs.push_back(mkVec(2, 0, 4'h9, 0, 32'h00));
    vecs.push_back(mkVec(1, 0, 4'h0, 0, 32'h00));
    vecs.push_back(mkVec(0, 0, 4'hE, 0, 32'h00));
    vecs.push_back(mkVec(2, 0, 4'hA, 0, 32'h00));
    vecs.push_back(mkVec(0, 1, 4'h0, 32'hd4, 0));
    vecs.push_back(mkVec(0, 1, 4'h1, 32'hc3, 0));
    vecs.push_back(mkVec(0, 1, 4'h2, 32'hb2, 0));
    vecs.push_back(mkVec(0, 1, 4'h3, 32'ha1, 0));
    for (int k = 1; k <= 6; k++) begin
      vecs.push_back(mkVec(0, 1, 4'h8, 32'(k * 17), 0));
      vecs.push_back(mkVec(0, 1, 4'h9, 0, 0));
    end
    vecs.push_back(mkVec(0, 0, 4'hD, 0, 32'h49));
    vecs.push_back(mkVec(0, 1, 4'hD, 0, 0));
    vecs.push_back(mkVec(0, 0, 4'hD, 0, 32'h41));

    doReset();

    s0 = starts[0];
    for (int k = 0; k < vecs.size(); k++) applyStimulus(vecs[k], k);
    checkOutput("ovf_issued", 32'(starts[0] - s0), 32'd1);
    checkOutput("ovf_core_op", 32'(core_op_v[0]), 32'h11);
    checkOutput("ovf_core_a", core_a_v[0], 32'ha1b2c3d4);
    checkOutput("ovf_busy", 32'(busy_v[0]), 32'd1);
    busRead(0, 4'hD, rdata);
    checkOutput("ovf_status_again", rdata, 32'h41);

    // Read strobe high must leave the bus at zero even when selected.
    @(negedge clk);
    cs_v[0] = 1'b0; addr = 4'hD;
    #1 checkOutput("no_rd_dout", dout_v[0], 32'd0);
    cs_v[0] = 1'b1;

    doReset();

    // Single command on the 8-bit bus with exact issue and completion timing.
    pushCmd(0, 32'h4d96890d, 32'h3c3c00ff, 8'h07, 32'h468ad2e8, 1'b1);
    waitStart(0, waited);
    checkOutput("issue_latency", 32'(waited), 32'd1);
    respond(0, 8);
    checkOutput("cmd_end_d0", 32'(cmd_end_v[0]), 32'd0);
    @(negedge clk);
    checkOutput("cmd_end_d1", 32'(cmd_end_v[0]), 32'd0);
    @(negedge clk);
    checkOutput("cmd_end_d2", 32'(cmd_end_v[0]), 32'd1);
    checkOutput("busy_done", 32'(busy_v[0]), 32'd0);
    busRead(0, 4'hD, rdata);
    checkOutput("status_result", rdata, 32'h06);
    readResult(0, "res_dw8");
    ackPulse(0);
    @(negedge clk);
    checkOutput("cmd_end_ack", 32'(cmd_end_v[0]), 32'd0);
    busRead(0, 4'h9, rdata);
    checkOutput("res_empty_read", rdata, 32'd0);
    ackPulse(0);
    busRead(0, 4'hD, rdata);
    checkOutput("ack_empty_status", rdata, 32'h02);

    // Result backpressure on the depth-2 instance; staging A/B reused across pushes.
    s0 = starts[1];
    pushCmd(1, 32'h01020304, 32'hf0e0d0c0, 8'h01, 32'h11111111, 1'b1);
    waitStart(1, waited);
    pushCmd(1, 32'h01020304, 32'hf0e0d0c0, 8'h02, 32'h22222222, 1'b0);
    pushCmd(1, 32'h01020304, 32'hf0e0d0c0, 8'h03, 32'h33333333, 1'b0);
    respond(1, 3);
    waitStart(1, waited);
    respond(1, 3);
    repeat (20) @(negedge clk);
    checkOutput("bp_starts2", 32'(starts[1] - s0), 32'd2);
    checkOutput("bp_cmd_end", 32'(cmd_end_v[1]), 32'd1);
    checkOutput("bp_busy", 32'(busy_v[1]), 32'd1);
    busRead(1, 4'hD, rdata);
    checkOutput("bp_status", rdata, 32'h14);
    readResult(1, "bp_res1");
    ackPulse(1);
    waitStart(1, waited);
    respond(1, 3);
    checkOutput("bp_starts3", 32'(starts[1] - s0), 32'd3);
    readResult(1, "bp_res2");
    ackPulse(1);
    repeat (2) @(negedge clk);
    readResult(1, "bp_res3");
    ackPulse(1);
    repeat (2) @(negedge clk);
    checkOutput("bp_cmd_end_clear", 32'(cmd_end_v[1]), 32'd0);
    busRead(1, 4'hD, rdata);
    checkOutput("bp_status_idle", rdata, 32'h02);

    // Full-width bus: one write per operand, one read for the result.
    pushCmd(2, 32'hcafe1234, 32'h0badf00d, 8'h3c, 32'h89abcdef, 1'b1);
    waitStart(2, waited);
    respond(2, 5);
    waitCmdEnd(2);
    readResult(2, "res_dw32");
    ackPulse(2);

    // Reset while the core is busy: a late core_done must not produce a result.
    pushCmd(0, 32'h13572468, 32'h0f0f0f0f, 8'h99, 32'h55aa55aa, 1'b1);
    waitStart(0, waited);
    repeat (3) @(negedge clk);
    checkOutput("wait_busy", 32'(busy_v[0]), 32'd1);
    doReset();
    core_done_v[0] = 1'b1; core_result_v[0] = 32'h55aa55aa;
    @(negedge clk);
    core_done_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abandon_cmd_end", 32'(cmd_end_v[0]), 32'd0);
    checkOutput("abandon_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("abandon_start", 32'(starts[0] - s0 >= 0 ? start_v[0] : 1'b1), 32'd0);
    busRead(0, 4'hD, rdata);
    checkOutput("abandon_status", rdata, 32'h02);
    busRead(0, 4'h9, rdata);
    checkOutput("abandon_res", rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
